// File: rtl/wrapper_b2a_mask_supply_if.sv
// Handshake and mask-word bundle between the mask supply and the B2A wrapper.
// master = supply side (drives z words), slave = consumer side.
interface wrapper_b2a_mask_supply_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 flush;
  logic                 seed_load;
  logic [BIT_WIDTH-1:0] seed;
  logic                 take;
  logic [BIT_WIDTH-1:0] z0;
  logic [BIT_WIDTH-1:0] z1;
  logic [BIT_WIDTH-1:0] z2;
  logic [BIT_WIDTH-1:0] z3;
  logic [BIT_WIDTH-1:0] z4;
  logic [BIT_WIDTH-1:0] z5;
  logic                 z_valid;
  logic [2:0]           fill_count;

  modport master (
    input  flush, seed_load, seed, take,
    output z0, z1, z2, z3, z4, z5, z_valid, fill_count
  );

  modport slave (
    output flush, seed_load, seed, take,
    input  z0, z1, z2, z3, z4, z5, z_valid, fill_count
  );
endinterface

// File: rtl/wrapper_b2a_mask_supply.sv
// Double-buffered xorshift32 mask supply: the back bank refills one word per
// edge while the front bank holds six stable words for the B2A wrapper.
module wrapper_b2a_mask_supply #(
  parameter int          BIT_WIDTH = 32,
  parameter logic [31:0] SEED      = 32'h00000001
) (
  input  logic                          g_clk,
  input  logic                          g_reset,
  wrapper_b2a_mask_supply_if.master     bus
);
  localparam int NWORDS = 6;
  // An all-zero state would lock xorshift at zero forever.
  localparam logic [BIT_WIDTH-1:0] SEED_INIT =
    (SEED == 32'd0) ? BIT_WIDTH'(1) : BIT_WIDTH'(SEED);

  function automatic logic [BIT_WIDTH-1:0] xs_next(input logic [BIT_WIDTH-1:0] v);
    logic [BIT_WIDTH-1:0] t;
    t = v ^ (v << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  logic [BIT_WIDTH-1:0] s_reg;
  logic [BIT_WIDTH-1:0] back_reg  [NWORDS];
  logic [BIT_WIDTH-1:0] front_reg [NWORDS];
  logic [2:0]           bcnt_reg;
  logic                 fvalid_reg;

  logic [BIT_WIDTH-1:0] gen_next;
  logic [BIT_WIDTH-1:0] seed_fixed;
  logic                 fill;
  logic                 xfer;

  assign gen_next   = xs_next(s_reg);
  assign seed_fixed = (bus.seed == '0) ? BIT_WIDTH'(1) : bus.seed;
  assign fill       = (bcnt_reg < 3'd6);
  assign xfer       = (bcnt_reg == 3'd6) && (!fvalid_reg || bus.take);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      s_reg      <= SEED_INIT;
      bcnt_reg   <= 3'd0;
      fvalid_reg <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        front_reg[i] <= '0;
        back_reg[i]  <= '0;
      end
    end else if (bus.flush) begin
      bcnt_reg   <= 3'd0;
      fvalid_reg <= 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
        front_reg[i] <= '0;
      end
    end else if (bus.seed_load) begin
      s_reg    <= seed_fixed;
      bcnt_reg <= 3'd0;
    end else begin
      if (fill) begin
        for (int i = 0; i < NWORDS; i++) begin
          if (bcnt_reg == 3'(i)) begin
            back_reg[i] <= gen_next;
          end
        end
        s_reg    <= gen_next;
        bcnt_reg <= bcnt_reg + 3'd1;
      end
      // fill and xfer are mutually exclusive, so bcnt has a single writer here.
      if (xfer) begin
        for (int i = 0; i < NWORDS; i++) begin
          front_reg[i] <= back_reg[i];
        end
        fvalid_reg <= 1'b1;
        bcnt_reg   <= 3'd0;
      end else if (bus.take && fvalid_reg) begin
        fvalid_reg <= 1'b0;
      end
    end
  end

  assign bus.z0         = front_reg[0];
  assign bus.z1         = front_reg[1];
  assign bus.z2         = front_reg[2];
  assign bus.z3         = front_reg[3];
  assign bus.z4         = front_reg[4];
  assign bus.z5         = front_reg[5];
  assign bus.z_valid    = fvalid_reg;
  assign bus.fill_count = bcnt_reg;
endmodule

// File: tb/tb_wrapper_b2a_mask_supply.sv
// Directed bench for the mask supply: latency, take/refill, flush, seed and
// back-to-back bank uniqueness against a small xorshift32 reference.
module tb_wrapper_b2a_mask_supply;
  logic g_clk = 1'b0;
  logic g_reset;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] ms;
  logic [31:0] exp_bank [6];
  logic [31:0] held     [6];

  always #5 g_clk = ~g_clk;

  wrapper_b2a_mask_supply_if #(.BIT_WIDTH(32)) bus ();

  wrapper_b2a_mask_supply #(.BIT_WIDTH(32), .SEED(32'h00000001)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  function automatic logic [31:0] ref_next(input logic [31:0] v);
    logic [31:0] a;
    a = v ^ {v[18:0], 13'd0};
    a = a ^ {17'd0, a[31:17]};
    return a ^ {a[26:0], 5'd0};
  endfunction

  function automatic logic [31:0] zw(input int i);
    case (i)
      0: return bus.z0;
      1: return bus.z1;
      2: return bus.z2;
      3: return bus.z3;
      4: return bus.z4;
      default: return bus.z5;
    endcase
  endfunction

  task automatic make_bank();
    for (int i = 0; i < 6; i++) begin
      ms = ref_next(ms);
      exp_bank[i] = ms;
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    g_reset = 1'b1; bus.flush = 1'b1; bus.take = 1'b1;
    bus.seed_load = 1'b0; bus.seed = 32'd0;
    tick(); tick();
    checks++; if (bus.z_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.z_valid); end
    checks++; if (bus.fill_count !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", bus.fill_count); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (zw(i) !== 32'd0) begin failures++; $display("FAIL reset_z%0d got=%h exp=0", i, zw(i)); end
    end
    g_reset = 1'b0; bus.flush = 1'b0; bus.take = 1'b0;
    ms = 32'd1;
    $display("test_reset done");
  endtask

  task automatic test_first_bank();
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++; if (bus.fill_count !== 3'(e)) begin failures++; $display("FAIL first_fill edge%0d got=%0d exp=%0d", e, bus.fill_count, e); end
      checks++; if (bus.z_valid !== 1'b0) begin failures++; $display("FAIL first_early_valid edge%0d got=%b exp=0", e, bus.z_valid); end
    end
    tick();
    make_bank();
    checks++; if (bus.z_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", bus.z_valid); end
    checks++; if (bus.z0 !== 32'h00042021) begin failures++; $display("FAIL first_z0 got=%h exp=00042021", bus.z0); end
    checks++; if (bus.z1 !== 32'h04080601) begin failures++; $display("FAIL first_z1 got=%h exp=04080601", bus.z1); end
    for (int i = 2; i < 6; i++) begin
      checks++; if (zw(i) !== exp_bank[i]) begin failures++; $display("FAIL first_z%0d got=%h exp=%h", i, zw(i), exp_bank[i]); end
    end
    checks++; if (bus.fill_count !== 3'd0) begin failures++; $display("FAIL first_fill_after got=%0d exp=0", bus.fill_count); end
    $display("test_first_bank z0=%h", bus.z0);
  endtask

  task automatic test_take_full();
    int n;
    for (int i = 0; i < 6; i++) held[i] = zw(i);
    n = 0;
    while (bus.fill_count !== 3'd6 && n < 20) begin tick(); n++; end
    checks++; if (bus.fill_count !== 3'd6) begin failures++; $display("FAIL full_wait got=%0d exp=6", bus.fill_count); end
    checks++; if (zw(0) !== held[0] || bus.z_valid !== 1'b1) begin failures++; $display("FAIL full_hold got=%h/%b exp=%h/1", zw(0), bus.z_valid, held[0]); end
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    make_bank();
    checks++; if (bus.z_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", bus.z_valid); end
    checks++; if (bus.fill_count !== 3'd0) begin failures++; $display("FAIL full_fill got=%0d exp=0", bus.fill_count); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (zw(i) !== exp_bank[i]) begin failures++; $display("FAIL full_z%0d got=%h exp=%h", i, zw(i), exp_bank[i]); end
    end
    $display("test_take_full z0=%h", bus.z0);
  endtask

  task automatic test_take_refill();
    tick(); tick(); tick();
    checks++; if (bus.fill_count !== 3'd3) begin failures++; $display("FAIL refill_pre got=%0d exp=3", bus.fill_count); end
    for (int i = 0; i < 6; i++) held[i] = zw(i);
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    checks++; if (bus.z_valid !== 1'b0) begin failures++; $display("FAIL refill_drop got=%b exp=0", bus.z_valid); end
    checks++; if (bus.fill_count !== 3'd4) begin failures++; $display("FAIL refill_fill got=%0d exp=4", bus.fill_count); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (zw(i) !== held[i]) begin failures++; $display("FAIL refill_hold_z%0d got=%h exp=%h", i, zw(i), held[i]); end
    end
    tick(); tick();
    checks++; if (bus.fill_count !== 3'd6 || bus.z_valid !== 1'b0) begin failures++; $display("FAIL refill_at6 got=%0d/%b exp=6/0", bus.fill_count, bus.z_valid); end
    tick();
    make_bank();
    checks++; if (bus.z_valid !== 1'b1) begin failures++; $display("FAIL refill_rise got=%b exp=1", bus.z_valid); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (zw(i) !== exp_bank[i]) begin failures++; $display("FAIL refill_z%0d got=%h exp=%h", i, zw(i), exp_bank[i]); end
    end
    $display("test_take_refill z0=%h", bus.z0);
  endtask

  task automatic test_flush();
    tick(); tick();
    ms = ref_next(ref_next(ms));
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    checks++; if (bus.z_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", bus.z_valid); end
    checks++; if (bus.fill_count !== 3'd0) begin failures++; $display("FAIL flush_fill got=%0d exp=0", bus.fill_count); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (zw(i) !== 32'd0) begin failures++; $display("FAIL flush_z%0d got=%h exp=0", i, zw(i)); end
    end
    for (int e = 0; e < 7; e++) tick();
    make_bank();
    checks++; if (bus.z_valid !== 1'b1) begin failures++; $display("FAIL flush_next_valid got=%b exp=1", bus.z_valid); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (zw(i) !== exp_bank[i]) begin failures++; $display("FAIL flush_cont_z%0d got=%h exp=%h", i, zw(i), exp_bank[i]); end
    end
    $display("test_flush z0=%h", bus.z0);
  endtask

  task automatic test_seed_zero();
    for (int i = 0; i < 6; i++) held[i] = zw(i);
    bus.seed = 32'd0; bus.seed_load = 1'b1; tick(); bus.seed_load = 1'b0;
    checks++; if (bus.fill_count !== 3'd0) begin failures++; $display("FAIL seed_fill got=%0d exp=0", bus.fill_count); end
    checks++; if (bus.z_valid !== 1'b1 || zw(0) !== held[0]) begin failures++; $display("FAIL seed_front got=%h/%b exp=%h/1", zw(0), bus.z_valid, held[0]); end
    ms = 32'd1;
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    for (int e = 0; e < 6; e++) tick();
    make_bank();
    checks++; if (bus.z_valid !== 1'b1) begin failures++; $display("FAIL seed_valid got=%b exp=1", bus.z_valid); end
    checks++; if (bus.z0 !== 32'h00042021) begin failures++; $display("FAIL seed_z0 got=%h exp=00042021", bus.z0); end
    checks++; if (bus.z1 !== 32'h04080601) begin failures++; $display("FAIL seed_z1 got=%h exp=04080601", bus.z1); end
    checks++; if (bus.z5 !== exp_bank[5]) begin failures++; $display("FAIL seed_z5 got=%h exp=%h", bus.z5, exp_bank[5]); end
    $display("test_seed_zero z0=%h", bus.z0);
  endtask

  task automatic test_simultaneous();
    bus.flush = 1'b1; bus.seed_load = 1'b1; bus.seed = 32'hDEADBEEF;
    tick();
    bus.flush = 1'b0; bus.seed_load = 1'b0;
    checks++; if (bus.z_valid !== 1'b0 || bus.fill_count !== 3'd0 || bus.z0 !== 32'd0) begin failures++; $display("FAIL flushseed_state got=%b/%0d/%h exp=0/0/0", bus.z_valid, bus.fill_count, bus.z0); end
    for (int e = 0; e < 7; e++) tick();
    make_bank();
    checks++; if (bus.z0 !== exp_bank[0]) begin failures++; $display("FAIL flushseed_s_kept got=%h exp=%h", bus.z0, exp_bank[0]); end
    tick(); tick();
    g_reset = 1'b1; bus.flush = 1'b1; bus.take = 1'b1;
    tick();
    g_reset = 1'b0; bus.flush = 1'b0; bus.take = 1'b0;
    checks++; if (bus.z_valid !== 1'b0 || bus.fill_count !== 3'd0) begin failures++; $display("FAIL rstmix_ctrl got=%b/%0d exp=0/0", bus.z_valid, bus.fill_count); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (zw(i) !== 32'd0) begin failures++; $display("FAIL rstmix_z%0d got=%h exp=0", i, zw(i)); end
    end
    ms = 32'd1;
    for (int e = 0; e < 7; e++) tick();
    make_bank();
    checks++; if (bus.z0 !== 32'h00042021 || bus.z_valid !== 1'b1) begin failures++; $display("FAIL rstmix_restart got=%h/%b exp=00042021/1", bus.z0, bus.z_valid); end
    $display("test_simultaneous done");
  endtask

  task automatic test_back_to_back();
    bit seen [logic [31:0]];
    int n;
    bus.take = 1'b1; tick(); bus.take = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (bus.z_valid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++;
      if (bus.z_valid !== 1'b1) begin
        failures++; $display("FAIL b2b_timeout bank%0d got=%b exp=1", k, bus.z_valid);
        break;
      end
      if (n != 6) begin failures++; $display("FAIL b2b_period bank%0d got=%0d exp=6", k, n); end
      make_bank();
      for (int i = 0; i < 6; i++) begin
        checks++; if (zw(i) !== exp_bank[i]) begin failures++; $display("FAIL b2b_z%0d bank%0d got=%h exp=%h", i, k, zw(i), exp_bank[i]); end
        checks++; if (seen.exists(zw(i))) begin failures++; $display("FAIL b2b_reuse bank%0d word=%h got=repeat exp=fresh", k, zw(i)); end
        seen[zw(i)] = 1'b1;
      end
      $display("bank %0d z0=%h z5=%h", k, bus.z0, bus.z5);
      bus.take = 1'b1; tick(); bus.take = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_first_bank();
    test_take_full();
    test_take_refill();
    test_flush();
    test_seed_zero();
    test_simultaneous();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
